// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: round-robin arbitration of read and write clients onto one
// two-port SRAM. A read that hits the granted write address is held off a cycle.
module sram_bank_arbiter #(
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int L_DATA = 16,
    parameter int L_ADDR = 13,
    parameter int L_RID  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_req_valid,
    input  logic [NUM_RD*L_ADDR-1:0] rd_req_addr,
    output logic [NUM_RD-1:0]        rd_req_ready,
    output logic                     rd_rsp_valid,
    output logic [L_RID-1:0]         rd_rsp_id,
    output logic [L_DATA-1:0]        rd_rsp_data,
    input  logic [NUM_WR-1:0]        wr_req_valid,
    input  logic [NUM_WR*L_ADDR-1:0] wr_req_addr,
    input  logic [NUM_WR*L_DATA-1:0] wr_req_data,
    output logic [NUM_WR-1:0]        wr_req_ready,
    output logic [L_ADDR-1:0]        sram_wAddr,
    output logic [L_DATA-1:0]        sram_wData,
    output logic                     sram_wEn,
    output logic [L_ADDR-1:0]        sram_rAddr,
    output logic                     sram_rEn,
    input  logic [L_DATA-1:0]        sram_rData
);

    localparam int L_WID = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [L_RID-1:0]  rdPtr_r;
    logic [L_WID-1:0]  wrPtr_r;
    logic [L_ADDR-1:0] wAddrHold_r;
    logic [L_DATA-1:0] wDataHold_r;
    logic [L_ADDR-1:0] rAddrHold_r;

    logic [L_ADDR-1:0] rdAddr_s [NUM_RD];
    logic [L_ADDR-1:0] wrAddr_s [NUM_WR];
    logic [L_DATA-1:0] wrData_s [NUM_WR];

    logic              rdWin_s;
    logic [L_RID-1:0]  rdWinIdx_s;
    logic              wrWin_s;
    logic [L_WID-1:0]  wrWinIdx_s;
    logic              wrGnt_s;
    logic              rdGnt_s;
    logic              collide_s;

    for (genvar g = 0; g < NUM_RD; g++) begin : gUnpackRd
        assign rdAddr_s[g] = rd_req_addr[g*L_ADDR +: L_ADDR];
    end

    for (genvar g = 0; g < NUM_WR; g++) begin : gUnpackWr
        assign wrAddr_s[g] = wr_req_addr[g*L_ADDR +: L_ADDR];
        assign wrData_s[g] = wr_req_data[g*L_DATA +: L_DATA];
    end

    // Read round-robin search: scanning downward lets the client nearest rdPtr_r win
    always_comb begin
        int idx;
        idx        = 0;
        rdWin_s    = |rd_req_valid;
        rdWinIdx_s = '0;
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            idx        = (int'(rdPtr_r) + i) % NUM_RD;
            rdWinIdx_s = rd_req_valid[idx[L_RID-1:0]] ? idx[L_RID-1:0] : rdWinIdx_s;
        end
    end

    // Write round-robin search, same scheme anchored at wrPtr_r
    always_comb begin
        int idx;
        idx        = 0;
        wrWin_s    = |wr_req_valid;
        wrWinIdx_s = '0;
        for (int i = NUM_WR - 1; i >= 0; i--) begin
            idx        = (int'(wrPtr_r) + i) % NUM_WR;
            wrWinIdx_s = wr_req_valid[idx[L_WID-1:0]] ? idx[L_WID-1:0] : wrWinIdx_s;
        end
    end

    // A read colliding with the granted write yields; it sees the new data next cycle
    assign wrGnt_s   = wrWin_s & ~rst;
    assign collide_s = wrGnt_s & rdWin_s & (rdAddr_s[rdWinIdx_s] == wrAddr_s[wrWinIdx_s]);
    assign rdGnt_s   = rdWin_s & ~rst & ~collide_s;

    // One-hot ready vectors from the qualified grants
    always_comb begin
        rd_req_ready = '0;
        wr_req_ready = '0;
        if (rdGnt_s) begin
            rd_req_ready[rdWinIdx_s] = 1'b1;
        end else begin
            rd_req_ready = '0;
        end
        if (wrGnt_s) begin
            wr_req_ready[wrWinIdx_s] = 1'b1;
        end else begin
            wr_req_ready = '0;
        end
    end

    // Idle cycles replay the last granted address/data so the macro pins stay quiet
    assign sram_wEn    = ~wrGnt_s;
    assign sram_wAddr  = wrGnt_s ? wrAddr_s[wrWinIdx_s] : wAddrHold_r;
    assign sram_wData  = wrGnt_s ? wrData_s[wrWinIdx_s] : wDataHold_r;
    assign sram_rEn    = ~rdGnt_s;
    assign sram_rAddr  = rdGnt_s ? rdAddr_s[rdWinIdx_s] : rAddrHold_r;
    assign rd_rsp_data = sram_rData;

    // Priority pointers, held SRAM drive values and response tagging
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr_r      <= '0;
            wrPtr_r      <= '0;
            wAddrHold_r  <= '0;
            wDataHold_r  <= '0;
            rAddrHold_r  <= '0;
            rd_rsp_valid <= 1'b0;
            rd_rsp_id    <= '0;
        end else begin
            if (wrGnt_s) begin
                wrPtr_r     <= (wrWinIdx_s == L_WID'(NUM_WR - 1)) ? '0 : wrWinIdx_s + 1'b1;
                wAddrHold_r <= wrAddr_s[wrWinIdx_s];
                wDataHold_r <= wrData_s[wrWinIdx_s];
            end
            if (rdGnt_s) begin
                rdPtr_r     <= (rdWinIdx_s == L_RID'(NUM_RD - 1)) ? '0 : rdWinIdx_s + 1'b1;
                rAddrHold_r <= rdAddr_s[rdWinIdx_s];
                rd_rsp_id   <= rdWinIdx_s;
            end
            rd_rsp_valid <= rdGnt_s;
        end
    end

endmodule

// File: doc/sram_bank_arbiter.md
Name: sram_bank_arbiter

Overview:
- Shares one 8192x16 banked two-port SRAM (1 write port, 1 read port, active-low enables, 1-cycle read latency) between NUM_WR write clients and NUM_RD read clients.
- Per-port round-robin arbitration with valid/ready handshakes.
- Blocks a same-cycle read/write to the same address.
- Returns read data tagged with the requesting client's ID.
- Sits between the PE-array buffer clients and the SRAM macro wrapper.

Parameters:
- NUM_RD, 2, number of read clients (2..8)
- NUM_WR, 2, number of write clients (2..8)
- L_DATA, 16, data width
- L_ADDR, 13, address width (8192 words)
- L_RID, clogb2(NUM_RD), read-client ID width (minimum 1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_req_valid  in  NUM_RD  per-client read request
- rd_req_addr  in  NUM_RD*L_ADDR  flattened, client i at [i*L_ADDR +: L_ADDR]
- rd_req_ready  out  NUM_RD  one-hot grant (or zero)
- rd_rsp_valid  out  1  read data valid
- rd_rsp_id  out  L_RID  client index of returned data
- rd_rsp_data  out  L_DATA  returned data
- wr_req_valid  in  NUM_WR  per-client write request
- wr_req_addr  in  NUM_WR*L_ADDR  flattened as above
- wr_req_data  in  NUM_WR*L_DATA  flattened
- wr_req_ready  out  NUM_WR  one-hot grant (or zero)
- sram_wAddr  out  L_ADDR  to SRAM write address
- sram_wData  out  L_DATA  to SRAM write data
- sram_wEn  out  1  active-low write enable
- sram_rAddr  out  L_ADDR  to SRAM read address
- sram_rEn  out  1  active-low read enable
- sram_rData  in  L_DATA  SRAM read data, valid the cycle after the rEn-low cycle

Behaviour:
- Handshake: a transfer occurs when valid and ready are both high in the same cycle. Grants are combinational from the valid inputs and the registered priority pointers; ready never depends on the client's own ready. A client must hold valid/addr/data until it is granted.
- Write arbitration:
  - wr_ptr is a register pointing at the highest-priority client.
  - Grant goes to the first valid client scanning wr_ptr, wr_ptr+1, ... modulo NUM_WR.
  - On a grant to client k, wr_ptr <= (k+1) mod NUM_WR. With no grant, wr_ptr holds.
- Read arbitration: same scheme with rd_ptr.
- SRAM drive:
  - On a write grant: sram_wEn=0, sram_wAddr/sram_wData from the granted client. Otherwise sram_wEn=1 and the address/data outputs hold the last granted values (held in registers, no toggling) to limit switching power.
  - Reads use sram_rEn and sram_rAddr under the same rule.
- Collision: if the winning read address equals the granted write address in the same cycle:
  - The read grant is suppressed: rd_req_ready all zero, sram_rEn=1, rd_ptr unchanged.
  - The write proceeds.
  - The read wins next cycle (if still valid) and returns the newly written data.
- Read response:
  - rd_rsp_valid <= read granted this cycle. rd_rsp_id <= granted index.
  - rd_rsp_data = sram_rData, passed through combinationally.
  - Latency is 1 cycle from grant to rsp_valid. Back-to-back grants give back-to-back responses, for a throughput of 1 read + 1 write per cycle. Clients have no backpressure on responses.
- Reset (async):
  - rd_ptr=0, wr_ptr=0, rd_rsp_valid=0, rd_rsp_id=0.
  - Held address/data registers reset to 0.
  - While rst is high: all ready outputs 0, sram_wEn=1, sram_rEn=1.
  - A read granted the cycle before reset asserts is discarded; no response appears after reset releases.
- Simultaneous events:
  - Read and write to different addresses, same or different banks: both granted (two-port macro).
  - All clients valid continuously: strict rotation 0,1,..,N-1,0, with no starvation.
- Width rules: addresses are passed unmodified; bank select stays in the top 2 address bits and is decoded inside the SRAM wrapper.

Test Plan:
- Reset: assert rst mid-stream with rd0 valid -> ready=0, sram_wEn=sram_rEn=1, rd_rsp_valid=0, and no response after release.
- Single write then read: wr0 addr 0x1805 data 0xBEEF; next cycle rd1 addr 0x1805 -> rd_rsp_valid=1, id=1, data=0xBEEF one cycle after the rd1 grant.
- Round-robin: rd0 and rd1 both valid for 4 cycles (addrs 0x0010/0x0810, preloaded 0x1111/0x2222) -> grants 0,1,0,1; responses id 0,1,0,1 with matching data.
- Collision: same cycle wr0 addr 0x0400 data 0x00A5 and rd0 addr 0x0400 (old value 0x5A00) -> write granted, rd ready=0; read granted next cycle and returns 0x00A5.
- Concurrency: wr1 to 0x1FFF and rd0 to 0x0000 every cycle for 8 cycles -> both granted each cycle, sram_wEn=sram_rEn=0 throughout, 8 responses.
- Idle: no valid inputs -> enables stay 1, SRAM address/data outputs stable, pointers unchanged.
